// File: rtl/column_drop_engine.sv
// Column-drop game engine: per-column fill counters, alternating player, and a
// request/present handshake for placed cells. Optional undo via COLUMN_DROP_UNDO_EN.
module column_drop_engine #(
  parameter int COLS = 4,
  parameter int ROWS = 4,
  localparam int POS_W = $clog2(COLS * ROWS) + 1,
  localparam int CNT_W = $clog2(ROWS + 1),
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             drop_req,
  input  logic [COLS-1:0]  sel_n,
  output logic             ready,
  output logic             pos_valid,
  output logic [POS_W-1:0] pos,
  output logic             pos_player,
  input  logic             pos_ack,
  output logic             reject,
  output logic [COLS-1:0]  col_full,
  output logic             board_full,
  input  logic             undo_req,
  output logic             undo_flag,
  output logic [1:0]       dbg_state
);

  // Handshake: a request is taken on a rising edge where ready=1; a presented
  // cell (pos_valid=1) holds pos/pos_player/undo_flag until an edge with pos_ack=1.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CHECK   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  localparam logic [POS_W-1:0] NO_POS = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt [COLS];
  logic             r_player;
  logic             r_pos_valid;
  logic [POS_W-1:0] r_pos;
  logic             r_pos_player;
  logic             r_reject;
  logic [COL_W-1:0] r_col;

  logic [COLS-1:0]  w_low;
  logic             w_one_hot;
  logic [COL_W-1:0] w_col;
  logic             w_ok;
  logic             w_accept_drop;
  logic [POS_W-1:0] w_dpos;
  logic [COLS-1:0]  w_col_full;

  assign w_low     = ~sel_n;
  assign w_one_hot = (w_low != '0) && ((w_low & (w_low - 1'b1)) == '0);

  always_comb begin
    w_col = '0;
    for (int i = 0; i < COLS; i++) begin
      if (w_low[i]) w_col = COL_W'(i);
    end
  end

  // The select is decoded as it is latched so the reject pulse can be a
  // registered output that lands exactly on the CHECK cycle.
  assign w_ok          = w_one_hot && (r_cnt[w_col] != CNT_W'(ROWS));
  assign ready         = (r_state == S_IDLE) && enable;
  assign w_accept_drop = ready && drop_req && !clear;
  assign w_dpos        = POS_W'(r_cnt[r_col]) * POS_W'(COLS) + POS_W'(r_col);

  always_comb begin
    w_col_full = '0;
    for (int i = 0; i < COLS; i++) begin
      w_col_full[i] = (r_cnt[i] == CNT_W'(ROWS));
    end
  end

`ifdef COLUMN_DROP_UNDO_EN
  logic             r_hist_valid;
  logic [COL_W-1:0] r_hist_col;
  logic             r_undo_flag;
  logic [CNT_W-1:0] w_ucnt;
  logic [POS_W-1:0] w_upos;
  logic             w_accept_undo;

  assign w_ucnt        = r_cnt[r_hist_col] - 1'b1;
  assign w_upos        = POS_W'(w_ucnt) * POS_W'(COLS) + POS_W'(r_hist_col);
  assign w_accept_undo = ready && undo_req && !drop_req && !clear;
  assign undo_flag     = r_undo_flag;
`else
  logic w_undo_unused;
  assign w_undo_unused = undo_req;
  assign undo_flag     = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < COLS; i++) r_cnt[i] <= '0;
      r_player     <= 1'b0;
      r_pos_valid  <= 1'b0;
      r_pos        <= NO_POS;
      r_pos_player <= 1'b0;
      r_reject     <= 1'b0;
      r_col        <= '0;
`ifdef COLUMN_DROP_UNDO_EN
      r_hist_valid <= 1'b0;
      r_hist_col   <= '0;
      r_undo_flag  <= 1'b0;
`endif
    end else if (clear) begin
      r_state      <= S_IDLE;
      for (int i = 0; i < COLS; i++) r_cnt[i] <= '0;
      r_player     <= 1'b0;
      r_pos_valid  <= 1'b0;
      r_pos        <= NO_POS;
      r_pos_player <= 1'b0;
      r_reject     <= 1'b0;
`ifdef COLUMN_DROP_UNDO_EN
      r_hist_valid <= 1'b0;
      r_undo_flag  <= 1'b0;
`endif
    end else begin
      r_reject <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept_drop) begin
            r_col    <= w_col;
            r_reject <= ~w_ok;
            r_state  <= S_CHECK;
          end
`ifdef COLUMN_DROP_UNDO_EN
          else if (w_accept_undo) begin
            if (r_hist_valid) begin
              r_cnt[r_hist_col] <= w_ucnt;
              r_player          <= ~r_player;
              r_pos             <= w_upos;
              r_pos_player      <= ~r_player;
              r_pos_valid       <= 1'b1;
              r_undo_flag       <= 1'b1;
              r_hist_valid      <= 1'b0;
              r_state           <= S_PRESENT;
            end else begin
              r_reject <= 1'b1;
            end
          end
`endif
        end
        S_CHECK: begin
          if (!r_reject) begin
            r_pos        <= w_dpos;
            r_pos_player <= r_player;
            r_cnt[r_col] <= r_cnt[r_col] + 1'b1;
            r_player     <= ~r_player;
            r_pos_valid  <= 1'b1;
`ifdef COLUMN_DROP_UNDO_EN
            r_hist_valid <= 1'b1;
            r_hist_col   <= r_col;
`endif
            r_state      <= S_PRESENT;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_PRESENT: begin
          if (pos_ack) begin
            r_pos_valid  <= 1'b0;
            r_pos        <= NO_POS;
            r_pos_player <= 1'b0;
`ifdef COLUMN_DROP_UNDO_EN
            r_undo_flag  <= 1'b0;
`endif
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pos_valid  = r_pos_valid;
  assign pos        = r_pos;
  assign pos_player = r_pos_player;
  assign reject     = r_reject;
  assign col_full   = w_col_full;
  assign board_full = &w_col_full;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_column_drop_engine.sv
// Bench for column_drop_engine at default COLS=ROWS=4; the undo sequence is
// compiled in when COLUMN_DROP_UNDO_EN is defined.
module tb_column_drop_engine;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       clear;
  logic       drop_req;
  logic [3:0] sel_n;
  logic       ready;
  logic       pos_valid;
  logic [4:0] pos;
  logic       pos_player;
  logic       pos_ack;
  logic       reject;
  logic [3:0] col_full;
  logic       board_full;
  logic       undo_req;
  logic       undo_flag;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];

  typedef struct {
    logic [3:0] sel_n;
    bit         rej;
    logic [4:0] pos;
    logic       pl;
    logic [3:0] full;
  } vec_t;
  vec_t vecs[13];

  column_drop_engine dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .drop_req(drop_req), .sel_n(sel_n), .ready(ready), .pos_valid(pos_valid),
    .pos(pos), .pos_player(pos_player), .pos_ack(pos_ack), .reject(reject),
    .col_full(col_full), .board_full(board_full), .undo_req(undo_req),
    .undo_flag(undo_flag), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ack();
    pos_ack = 1'b1;
    @(negedge clk);
    pos_ack = 1'b0;
    chk("ack_valid_low", pos_valid, 0);
    chk("ack_pos_none", pos, 5'h1f);
    chk("ack_undo_flag", undo_flag, 0);
    chk("ack_ready", ready, enable);
  endtask

  // mode 0 = drop, 1 = undo, 2 = drop and undo together
  task automatic do_req(input int mode, input logic [3:0] s, input bit exp_rej,
                        input logic [4:0] exp_pos, input logic exp_pl, input bit do_ack);
    int k;
    logic [6:0] exp;
    logic [6:0] act;
    chk("ready_before", ready, 1);
    if (mode != 1) begin drop_req = 1'b1; sel_n = s; end
    if (mode != 0) undo_req = 1'b1;
    if (!exp_rej) exp_q.push_back({mode == 1, exp_pl, exp_pos});
    @(negedge clk);
    drop_req = 1'b0; undo_req = 1'b0; sel_n = 4'hf;
    chk("reject_pulse", reject, exp_rej);
    if (exp_rej) begin
      @(negedge clk);
      chk("reject_one_cycle", reject, 0);
      chk("no_pos_valid", pos_valid, 0);
    end else begin
      k = 1;
      while (!pos_valid && k < 4) begin
        @(negedge clk);
        k++;
      end
      chk("latency", k, (mode == 1) ? 1 : 2);
      if (pos_valid) begin
        exp = exp_q.pop_front();
        act = {undo_flag, pos_player, pos};
        chk("present", act, exp);
      end else if (exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      if (do_ack) ack();
    end
  endtask

  initial begin
    logic p;
    logic [3:0] s;
    reset = 1'b1; enable = 1'b1; clear = 1'b0; drop_req = 1'b0;
    sel_n = 4'hf; pos_ack = 1'b0; undo_req = 1'b0;

    vecs[0]  = '{4'b1110, 1'b0, 5'd0,  1'b0, 4'b0000};
    vecs[1]  = '{4'b1101, 1'b0, 5'd1,  1'b1, 4'b0000};
    vecs[2]  = '{4'b1101, 1'b0, 5'd5,  1'b0, 4'b0000};
    vecs[3]  = '{4'b1111, 1'b1, 5'd0,  1'b0, 4'b0000};
    vecs[4]  = '{4'b1100, 1'b1, 5'd0,  1'b0, 4'b0000};
    vecs[5]  = '{4'b0111, 1'b0, 5'd3,  1'b1, 4'b0000};
    vecs[6]  = '{4'b0111, 1'b0, 5'd7,  1'b0, 4'b0000};
    vecs[7]  = '{4'b0111, 1'b0, 5'd11, 1'b1, 4'b0000};
    vecs[8]  = '{4'b0111, 1'b0, 5'd15, 1'b0, 4'b1000};
    vecs[9]  = '{4'b0111, 1'b1, 5'd0,  1'b0, 4'b1000};
    vecs[10] = '{4'b1011, 1'b0, 5'd2,  1'b1, 4'b1000};
    vecs[11] = '{4'b0101, 1'b1, 5'd0,  1'b0, 4'b1000};
    vecs[12] = '{4'b1110, 1'b0, 5'd4,  1'b0, 4'b1000};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_pos_valid", pos_valid, 0);
    chk("rst_pos", pos, 5'h1f);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_player", pos_player, 0);
    chk("rst_reject", reject, 0);
    chk("rst_undo_flag", undo_flag, 0);
    chk("rst_col_full", col_full, 0);
    chk("rst_board_full", board_full, 0);
    chk("rst_state", dbg_state, 0);

    // table of drops and rejects
    for (int i = 0; i < 13; i++) begin
      do_req(0, vecs[i].sel_n, vecs[i].rej, vecs[i].pos, vecs[i].pl, 1'b1);
      chk("tbl_col_full", col_full, vecs[i].full);
      chk("tbl_board_full", board_full, 0);
    end

    // ack withheld: output held, further drops ignored
    do_req(0, 4'b1110, 1'b0, 5'd8, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drop_req = 1'b1; sel_n = 4'b1011;
      @(negedge clk);
      chk("hold_pos", pos, 5'd8);
      chk("hold_valid", pos_valid, 1);
      chk("hold_ready", ready, 0);
      chk("hold_state", dbg_state, 2);
    end
    drop_req = 1'b0; sel_n = 4'hf;
    ack();

    // clear overrides ack/drop during PRESENT
    do_req(0, 4'b1011, 1'b0, 5'd6, 1'b0, 1'b0);
    clear = 1'b1; pos_ack = 1'b1; drop_req = 1'b1; sel_n = 4'b1110;
    @(negedge clk);
    clear = 1'b0; pos_ack = 1'b0; drop_req = 1'b0; sel_n = 4'hf;
    chk("clr_valid", pos_valid, 0);
    chk("clr_pos", pos, 5'h1f);
    chk("clr_col_full", col_full, 0);
    chk("clr_ready", ready, 1);
    chk("clr_state", dbg_state, 0);
    do_req(0, 4'b0111, 1'b0, 5'd3, 1'b0, 1'b1);

    // fill the whole board from a fresh game
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    p = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        s = ~(4'b0001 << c);
        do_req(0, s, 1'b0, 5'(r * 4 + c), p, 1'b1);
        p = ~p;
      end
    end
    chk("fill_col_full", col_full, 4'hf);
    chk("fill_board_full", board_full, 1);
    do_req(0, 4'b1101, 1'b1, 5'd0, 1'b0, 1'b1);

    // enable gates only IDLE acceptance
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drop_req = 1'b1; sel_n = 4'b1110;
      @(negedge clk);
      chk("dis_ready", ready, 0);
      chk("dis_valid", pos_valid, 0);
      chk("dis_state", dbg_state, 0);
    end
    drop_req = 1'b0;
    enable = 1'b1;
    drop_req = 1'b1; sel_n = 4'b1110;
    @(negedge clk);
    drop_req = 1'b0; sel_n = 4'hf; enable = 1'b0;
    @(negedge clk);
    chk("en_mid_valid", pos_valid, 1);
    chk("en_mid_pos", pos, 5'd0);
    ack();
    enable = 1'b1;
    @(negedge clk);

    // undo behaviour (player is 1 here, counters col0=1)
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
`ifdef COLUMN_DROP_UNDO_EN
    do_req(0, 4'b1011, 1'b0, 5'd2, 1'b0, 1'b1);
    do_req(1, 4'hf,    1'b0, 5'd2, 1'b0, 1'b1);
    do_req(1, 4'hf,    1'b1, 5'd0, 1'b0, 1'b1);
    do_req(0, 4'b1011, 1'b0, 5'd2, 1'b0, 1'b1);
    do_req(2, 4'b1011, 1'b0, 5'd6, 1'b1, 1'b1);
    do_req(1, 4'hf,    1'b0, 5'd6, 1'b1, 1'b1);
`else
    undo_req = 1'b1;
    @(negedge clk);
    undo_req = 1'b0;
    chk("undo_ign_reject", reject, 0);
    chk("undo_ign_valid", pos_valid, 0);
    chk("undo_ign_ready", ready, 1);
    do_req(2, 4'b1011, 1'b0, 5'd2, 1'b0, 1'b1);
`endif

    // asynchronous reset while presenting
    do_req(0, 4'b1110, 1'b0, 5'd0, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("arst_valid", pos_valid, 0);
    chk("arst_pos", pos, 5'h1f);
    chk("arst_col_full", col_full, 0);
    chk("arst_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_req(0, 4'b1110, 1'b0, 5'd0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
